// File: rtl/psum_acc_scratch_pkg.sv
// Shared types and saturation helpers for the psum accumulator scratchpad.
package psum_acc_scratch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  // Wide working width for the saturating add; entries up to 62 bits fit without overflow.
  localparam int unsigned SAT_CALC_W = 64;

  typedef logic signed [SAT_CALC_W-1:0] sat_word_t;

  typedef struct packed {
    sat_word_t val;
    logic      sat;
  } sat_res_t;

  function automatic sat_word_t sat_max(input int unsigned w);
    sat_word_t one;
    one = 1;
    return (one <<< (w - 1)) - one;
  endfunction

  function automatic sat_word_t sat_min(input int unsigned w);
    sat_word_t one;
    one = 1;
    return -(one <<< (w - 1));
  endfunction

  // Sign-extended operands in, result clamped to the signed range of a w-bit entry.
  function automatic sat_res_t sat_add(input sat_word_t a, input sat_word_t b,
                                       input int unsigned w);
    sat_res_t  res;
    sat_word_t sum;
    sum     = a + b;
    res.val = sum;
    res.sat = 1'b0;
    if (sum > sat_max(w)) begin
      res.val = sat_max(w);
      res.sat = 1'b1;
    end else if (sum < sat_min(w)) begin
      res.val = sat_min(w);
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/psum_acc_scratch_drain.sv
// Drain engine: walks entries 0..num-1 with valid/ready, reports last beat and done.
module psum_drain_ctrl
  import psum_acc_scratch_pkg::*;
#(
  parameter int unsigned ADDR_LEN      = 4,
  parameter int unsigned SCRATCH_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                start,
  input  logic [ADDR_LEN:0]   num,
  input  logic                ready,
  output logic                valid,
  output logic                last,
  output logic                done,
  output logic                busy,
  output logic [ADDR_LEN-1:0] ptr,
  output logic                beat
);

  localparam logic [ADDR_LEN:0] DEPTH_W = (ADDR_LEN + 1)'(SCRATCH_DEPTH);

  drain_state_t        state, state_nxt;
  logic [ADDR_LEN:0]   num_q, num_nxt, num_clamped;
  logic [ADDR_LEN-1:0] ptr_nxt;

  // State, latched length and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      num_q <= '0;
      ptr   <= '0;
    end else if (clr) begin
      state <= IDLE;
      num_q <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      num_q <= num_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt   = state;
    num_nxt     = num_q;
    ptr_nxt     = ptr;
    valid       = 1'b0;
    last        = 1'b0;
    done        = 1'b0;
    beat        = 1'b0;
    num_clamped = (num > DEPTH_W) ? DEPTH_W : num;
    unique case (state)
      IDLE: begin
        if (start) begin
          num_nxt   = num_clamped;
          ptr_nxt   = '0;
          state_nxt = (num_clamped == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        valid = 1'b1;
        last  = ({1'b0, ptr} == (num_q - 1'b1));
        beat  = ready;
        if (ready) begin
          ptr_nxt = ptr + 1'b1;
          if (last) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy = (state != IDLE);
  end

endmodule

// File: rtl/psum_acc_scratch.sv
// Accumulating partial-sum scratchpad: overwrite/saturating-accumulate writes,
// per-entry write-count lock, read-and-clear drain port.
module psum_acc_scratch
  import psum_acc_scratch_pkg::*;
#(
  parameter int unsigned ADDR_LEN      = 4,
  parameter int unsigned SCRATCH_DEPTH = 16,
  parameter int unsigned SCRATCH_WIDTH = 16,
  parameter int unsigned CNT_LEN       = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            wen,
  input  logic                            acc_mode,
  input  logic [ADDR_LEN-1:0]             waddr,
  input  logic signed [SCRATCH_WIDTH-1:0] din,
  input  logic [CNT_LEN-1:0]              filt_len,
  input  logic [ADDR_LEN-1:0]             raddr,
  output logic signed [SCRATCH_WIDTH-1:0] dout,
  output logic                            rlocked,
  input  logic                            drain_start,
  input  logic [ADDR_LEN:0]               drain_num,
  output logic                            drain_valid,
  input  logic                            drain_ready,
  output logic signed [SCRATCH_WIDTH-1:0] drain_data,
  output logic                            drain_last,
  output logic                            drain_done,
  output logic                            busy,
  output logic                            drop_err,
  output logic                            sat_flag
);

  logic signed [SCRATCH_WIDTH-1:0] mem [SCRATCH_DEPTH];
  logic [CNT_LEN-1:0]              cnt [SCRATCH_DEPTH];

  logic [ADDR_LEN-1:0]             ptr;
  logic                            beat;
  logic                            waddr_ok, raddr_ok, wlocked, accept;
  sat_res_t                        sum_res;
  logic signed [SCRATCH_WIDTH-1:0] wr_val;
  logic                            wr_sat;

  psum_drain_ctrl #(
    .ADDR_LEN      (ADDR_LEN),
    .SCRATCH_DEPTH (SCRATCH_DEPTH)
  ) u_drain (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .start (drain_start),
    .num   (drain_num),
    .ready (drain_ready),
    .valid (drain_valid),
    .last  (drain_last),
    .done  (drain_done),
    .busy  (busy),
    .ptr   (ptr),
    .beat  (beat)
  );

  // Write acceptance and the value an accepted write would store.
  always_comb begin
    waddr_ok = (32'(waddr) < SCRATCH_DEPTH);
    wlocked  = 1'b0;
    if (waddr_ok) wlocked = (filt_len != '0) && (cnt[waddr] >= filt_len);
    accept   = wen && !busy && waddr_ok && !wlocked;
    sum_res  = sat_add(SAT_CALC_W'(mem[waddr]), SAT_CALC_W'(din), SCRATCH_WIDTH);
    if (acc_mode) begin
      wr_val = sum_res.val[SCRATCH_WIDTH-1:0];
      wr_sat = sum_res.sat;
    end else begin
      wr_val = din;
      wr_sat = 1'b0;
    end
  end

  // Combinational read port and drain data.
  always_comb begin
    raddr_ok   = (32'(raddr) < SCRATCH_DEPTH);
    dout       = '0;
    rlocked    = 1'b0;
    if (raddr_ok) begin
      dout    = mem[raddr];
      rlocked = (filt_len != '0) && (cnt[raddr] >= filt_len);
    end
    drain_data = mem[ptr];
  end

  // Storage, counters, sticky saturation flag and drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SCRATCH_DEPTH; i++) begin
        mem[i] <= '0;
        cnt[i] <= '0;
      end
      sat_flag <= 1'b0;
      drop_err <= 1'b0;
    end else if (clr) begin
      for (int unsigned i = 0; i < SCRATCH_DEPTH; i++) begin
        mem[i] <= '0;
        cnt[i] <= '0;
      end
      sat_flag <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= wen && !accept;
      // Writes are refused while busy, so a write and a drain beat never share a cycle.
      if (accept) begin
        mem[waddr] <= wr_val;
        cnt[waddr] <= cnt[waddr] + CNT_LEN'(1);
        if (wr_sat) sat_flag <= 1'b1;
      end
      if (beat) begin
        mem[ptr] <= '0;
        cnt[ptr] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_psum_acc_scratch.sv
// Self-checking bench for psum_acc_scratch: vector table, random vs. reference model,
// and hand-written drain / clear / reset sequences.
module tb_psum_acc_scratch;

  logic               clk = 1'b0;
  logic               rst, clr, wen, acc_mode;
  logic [3:0]         waddr, raddr, filt_len;
  logic signed [15:0] din, dout, drain_data;
  logic               rlocked, drain_start, drain_valid, drain_ready;
  logic [4:0]         drain_num;
  logic               drain_last, drain_done, busy, drop_err, sat_flag;

  int checks = 0;
  int errors = 0;

  int ref_mem [16];
  int ref_cnt [16];
  bit ref_sat;

  typedef struct {
    bit acc;
    int addr;
    int data;
    int filt;
    int exp_dout;
    bit exp_lock;
    bit exp_drop;
    bit exp_sat;
  } vec_t;

  vec_t vecs [11];

  psum_acc_scratch #(
    .ADDR_LEN      (4),
    .SCRATCH_DEPTH (16),
    .SCRATCH_WIDTH (16),
    .CNT_LEN       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .wen         (wen),
    .acc_mode    (acc_mode),
    .waddr       (waddr),
    .din         (din),
    .filt_len    (filt_len),
    .raddr       (raddr),
    .dout        (dout),
    .rlocked     (rlocked),
    .drain_start (drain_start),
    .drain_num   (drain_num),
    .drain_valid (drain_valid),
    .drain_ready (drain_ready),
    .drain_data  (drain_data),
    .drain_last  (drain_last),
    .drain_done  (drain_done),
    .busy        (busy),
    .drop_err    (drop_err),
    .sat_flag    (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input int d, input bit acc);
    @(negedge clk);
    wen = 1'b1; waddr = a[3:0]; din = d[15:0]; acc_mode = acc; raddr = a[3:0];
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    for (int i = 0; i < 16; i++) begin
      raddr = i[3:0];
      #1;
      chk(name, dout, 0);
    end
  endtask

  function automatic int clamp16(input int v, inout bit sat);
    if (v > 32767) begin sat = 1'b1; return 32767; end
    if (v < -32768) begin sat = 1'b1; return -32768; end
    return v;
  endfunction

  initial begin
    rst = 1'b1; clr = 1'b0; wen = 1'b0; acc_mode = 1'b0; waddr = '0; raddr = '0;
    din = '0; filt_len = 4'd1; drain_start = 1'b0; drain_num = '0; drain_ready = 1'b0;

    //                acc addr  data   filt  dout   lock drop sat
    vecs[0]  = '{1'b0, 3,   100,    0,   100,   0,   0,   0};
    vecs[1]  = '{1'b1, 3,   -30,    0,   70,    0,   0,   0};
    vecs[2]  = '{1'b0, 0,   32000,  0,   32000, 0,   0,   0};
    vecs[3]  = '{1'b1, 0,   1000,   0,   32767, 0,   0,   1};
    vecs[4]  = '{1'b0, 1,   -30000, 0,   -30000,0,   0,   1};
    vecs[5]  = '{1'b1, 1,   -10000, 0,   -32768,0,   0,   1};
    vecs[6]  = '{1'b0, 5,   7,      3,   7,     0,   0,   1};
    vecs[7]  = '{1'b1, 5,   0,      3,   7,     0,   0,   1};
    vecs[8]  = '{1'b1, 5,   5,      3,   12,    1,   0,   1};
    vecs[9]  = '{1'b1, 5,   9,      3,   12,    1,   1,   1};
    vecs[10] = '{1'b1, 5,   9,      0,   21,    0,   0,   1};

    // Reset state
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_rlocked", rlocked, 0);
    chk("rst_valid", drain_valid, 0);
    chk("rst_last", drain_last, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_sat", sat_flag, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    filt_len = 4'd0;

    // Vector table
    foreach (vecs[i]) begin
      filt_len = vecs[i].filt[3:0];
      wr(vecs[i].addr, vecs[i].data, vecs[i].acc);
      chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      chk($sformatf("vec%0d_lock", i), rlocked, vecs[i].exp_lock);
      chk($sformatf("vec%0d_drop", i), drop_err, vecs[i].exp_drop);
      chk($sformatf("vec%0d_sat", i), sat_flag, vecs[i].exp_sat);
    end

    // addr 3 has seen exactly two writes
    raddr = 4'd3; filt_len = 4'd2; #1;
    chk("cnt3_lock_at2", rlocked, 1);
    filt_len = 4'd3; #1;
    chk("cnt3_lock_at3", rlocked, 0);
    filt_len = 4'd0;

    // Drain with backpressure, plus a write attempted during the drain
    pulse_clr();
    chk("clr_sat", sat_flag, 0);
    for (int i = 0; i < 4; i++) wr(i, i + 1, 1'b0);
    @(negedge clk);
    drain_num = 5'd4; drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    chk("drain_busy", busy, 1);
    begin
      int k;
      int cyc;
      k = 0; cyc = 0;
      while (k < 4 && cyc < 40) begin
        drain_ready = (cyc % 2 == 0);
        wen = (cyc == 1); waddr = 4'd7; din = 16'sd55; acc_mode = 1'b0;
        #1;
        chk("drain_valid", drain_valid, 1);
        chk("drain_data", drain_data, k + 1);
        chk("drain_last", drain_last, (k == 3) ? 1 : 0);
        chk("drain_done_early", drain_done, 0);
        if (cyc == 2) chk("drain_drop", drop_err, 1);
        if (drain_ready && drain_valid) k++;
        cyc++;
        @(negedge clk);
      end
      if (k < 4) chk("drain_timeout", k, 4);
    end
    drain_ready = 1'b0; wen = 1'b0;
    #1;
    chk("drain_done", drain_done, 1);
    chk("drain_valid_off", drain_valid, 0);
    chk("drain_busy_done", busy, 1);
    @(negedge clk);
    #1;
    chk("drain_done_once", drain_done, 0);
    chk("drain_idle", busy, 0);
    chk_all_zero("drain_cleared");

    // Zero-length drain
    @(negedge clk);
    drain_num = 5'd0; drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0; #1;
    chk("zero_done", drain_done, 1);
    chk("zero_valid", drain_valid, 0);
    @(negedge clk); #1;
    chk("zero_done_off", drain_done, 0);
    chk("zero_idle", busy, 0);

    // clr mid-drain
    wr(0, 32000, 1'b0); wr(0, 1000, 1'b1); wr(1, 9, 1'b0); wr(2, -4, 1'b0);
    chk("pre_clr_sat", sat_flag, 1);
    @(negedge clk);
    drain_num = 5'd3; drain_start = 1'b1; drain_ready = 1'b0;
    @(negedge clk);
    drain_start = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; #1;
    chk("clr_busy", busy, 0);
    chk("clr_valid", drain_valid, 0);
    chk("clr_done", drain_done, 0);
    chk("clr_sat2", sat_flag, 0);
    chk_all_zero("clr_zero");
    @(negedge clk); #1;
    chk("clr_no_done", drain_done, 0);

    // async rst mid-drain
    wr(0, 32000, 1'b0); wr(0, 1000, 1'b1); wr(1, 9, 1'b0);
    @(negedge clk);
    drain_num = 5'd2; drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", drain_valid, 0);
    chk("arst_sat", sat_flag, 0);
    raddr = 4'd0; #1;
    chk("arst_dout", dout, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("arst_zero");
    @(negedge clk); #1;
    chk("arst_no_done", drain_done, 0);

    // Randomised writes against the reference model
    for (int i = 0; i < 16; i++) begin ref_mem[i] = 0; ref_cnt[i] = 0; end
    ref_sat = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int a, d, lim;
      bit acc, we, cl, locked, exp_drop;
      @(negedge clk);
      if (c % 25 == 0) filt_len = 4'($urandom_range(0, 4));
      we  = ($urandom_range(0, 3) != 0);
      acc = $urandom_range(0, 1);
      a   = $urandom_range(0, 7);
      d   = $urandom_range(0, 65535);
      if (d > 32767) d = d - 65536;
      cl  = (c % 100 == 50);
      wen = we; acc_mode = acc; waddr = a[3:0]; din = d[15:0]; clr = cl;
      raddr = $urandom_range(0, 1) ? a[3:0] : 4'($urandom_range(0, 15));
      lim = int'(filt_len);
      exp_drop = 1'b0;
      if (cl) begin
        for (int i = 0; i < 16; i++) begin ref_mem[i] = 0; ref_cnt[i] = 0; end
        ref_sat = 1'b0;
      end else if (we) begin
        locked = (lim != 0) && (ref_cnt[a] >= lim);
        if (locked) exp_drop = 1'b1;
        else begin
          ref_mem[a] = acc ? clamp16(ref_mem[a] + d, ref_sat) : d;
          ref_cnt[a] = (ref_cnt[a] + 1) % 16;
        end
      end
      @(posedge clk);
      #1;
      clr = 1'b0; wen = 1'b0;
      chk("rnd_dout", dout, ref_mem[raddr]);
      chk("rnd_lock", rlocked, ((lim != 0) && (ref_cnt[raddr] >= lim)) ? 1 : 0);
      chk("rnd_drop", drop_err, exp_drop);
      chk("rnd_sat", sat_flag, ref_sat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/psum_acc_scratch.md
# psum_acc_scratch

Parametrised accumulating partial-sum scratchpad for the PE datapath. Replaces plain overwrite-only psum storage: writes either overwrite or saturating-accumulate into an entry, each entry counts accepted writes and locks at a programmable limit, and a valid/ready drain engine streams finished entries out while clearing them (read-and-clear). Sits between the MAC output and the PE's psum output link.

## Interface
- ADDR_LEN, 4: address width
- SCRATCH_DEPTH, 16: number of entries (≤ 2^ADDR_LEN)
- SCRATCH_WIDTH, 16: signed entry width
- CNT_LEN, 4: per-entry write-counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of all entries/counters, aborts drain
- wen  in  1  write request
- acc_mode  in  1  1 = accumulate, 0 = overwrite
- waddr  in  ADDR_LEN  write address
- din  in  SCRATCH_WIDTH  signed write data
- filt_len  in  CNT_LEN  writes allowed per entry; 0 = unlimited
- raddr  in  ADDR_LEN  combinational read address
- dout  out  SCRATCH_WIDTH  mem[raddr], combinational
- rlocked  out  1  entry raddr has reached filt_len
- drain_start  in  1  start drain (sampled in IDLE only)
- drain_num  in  ADDR_LEN+1  entries to drain, from address 0, latched at start
- drain_valid  out  1  drain beat available
- drain_ready  in  1  consumer accepts beat
- drain_data  out  SCRATCH_WIDTH  mem[drain_ptr]
- drain_last  out  1  current beat is final
- drain_done  out  1  one-cycle pulse at end of drain
- busy  out  1  drain FSM not IDLE
- drop_err  out  1  one-cycle pulse: write dropped (busy or locked)
- sat_flag  out  1  sticky: any accumulate saturated; cleared by rst/clr

## Operation
- Write accepted when wen & !busy & !locked[waddr]; locked = (filt_len≠0) & (count ≥ filt_len).
- Accepted write: overwrite → mem = din; accumulate → mem = sat(mem + din), sum computed at SCRATCH_WIDTH+1 bits, clamped to [−2^(W−1), 2^(W−1)−1]; clamp sets sat_flag. count += 1 on every accepted write (zero data counts).
- wen not accepted → no state change, drop_err pulses next cycle.
- Drain FSM, states IDLE, DRAIN, DONE:
  - IDLE: drain_start → latch drain_num, ptr = 0; drain_num = 0 → DONE, else DRAIN.
  - DRAIN: drain_valid = 1. On valid & ready: mem[ptr] = 0, count[ptr] = 0, ptr += 1; if beat was last → DONE. drain_last = (ptr == num−1).
  - DONE: drain_done = 1 for one cycle → IDLE.
- busy = state ≠ IDLE. drain_data held stable while valid & !ready.
- clr: priority over write and drain; zeroes mem, counts, sat_flag; FSM → IDLE without drain_done.
- drain_start while busy ignored. drain_num > SCRATCH_DEPTH clamped to SCRATCH_DEPTH.

## Timing
- Reset values: dout = 0, rlocked = 0 (when filt_len≠0, count 0 → 0), drain_valid 0, drain_last 0, drain_done 0, busy 0, drop_err 0, sat_flag 0, all mem/counts 0, FSM IDLE.
- Write latency 1: value visible on dout the cycle after the accepting edge; same-cycle raddr = waddr returns old value.
- drain_start at edge N → drain_valid high from cycle N+1; one beat per cycle at full throughput; drain_done in the cycle after the last handshake; busy low the cycle after that.
- drop_err and drain_done are registered single-cycle pulses.
- rst mid-drain: immediate return to IDLE, outputs to reset values.

## Structure
- Shared package: FSM state enum (IDLE/DRAIN/DONE), signed saturation min/max constants as functions of SCRATCH_WIDTH, saturating-add function.
- One sub-module natural: psum_drain_ctrl (FSM, ptr, valid/last/done); storage, counters and write path stay in the top.

## Test plan
- Overwrite then accumulate: W=16, write 100 to addr 3 (overwrite), then +(−30) acc → dout(3) = 70, count 2.
- Saturation: addr 0 = 32000, acc +1000 → 32767, sat_flag = 1; acc −40000 style negative clamp → −32768.
- Lock: filt_len = 3, four writes to addr 5 → fourth dropped, drop_err pulse, rlocked = 1; filt_len = 0 → unlimited writes.
- Drain with backpressure: mem[0..3] = 1,2,3,4, drain_num = 4, ready toggling 1,0,1 → beats 1,2,3,4 in order, last on 4, data stable when stalled, entries read 0 afterwards, drain_done once.
- Writes during drain dropped with drop_err; drain_num = 0 → drain_done the cycle after start, no valid.
- clr mid-drain and async rst mid-drain → FSM IDLE, all entries 0, no drain_done, sat_flag 0.
